// File: rtl/mcs8_fetch_unit.sv
// MCS8 fetch front end: PC stack, ROM prefetch FIFO and 1/2/3-byte
// instruction assembler with a valid/ready hand-off to decode.
module mcs8_fetch_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int PC_W       = 14
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  output logic [PC_W-1:0] I_ADDR_O,
  input  logic [7:0]      I_DAT_I,
  output logic            INS_VALID_O,
  input  logic            INS_READY_I,
  output logic [7:0]      INS_ICODE_O,
  output logic [7:0]      INS_B2_O,
  output logic [7:0]      INS_B3_O,
  output logic [1:0]      INS_LEN_O,
  output logic [PC_W-1:0] INS_PC_O,
  output logic [PC_W-1:0] INS_NEXT_O,
  input  logic            BR_VALID_I,
  input  logic [1:0]      BR_TYPE_I,
  input  logic [PC_W-1:0] BR_ADDR_I,
  input  logic [PC_W-1:0] BR_LINK_I,
  output logic [2:0]      SP_O
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_OP, ST_B2, ST_B3, ST_OUT} asm_state_e;

  // Opcode length: 00xxx1x0 is two bytes, 01xxxxx0 is three, all else one.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    if (!op[7] && !op[6] && op[2] && !op[0]) return 2'd2;
    else if (!op[7] && op[6] && !op[0])      return 2'd3;
    else                                     return 2'd1;
  endfunction

  logic [PC_W-1:0]  stack_q [8];
  logic [PC_W-1:0]  stack_d [8];
  logic [2:0]       sp_q, sp_d, sp_inc;
  logic [7:0]       fifo_dat_q [FIFO_DEPTH];
  logic [7:0]       fifo_dat_d [FIFO_DEPTH];
  logic [PC_W-1:0]  fifo_tag_q [FIFO_DEPTH];
  logic [PC_W-1:0]  fifo_tag_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pend_q, pend_d;
  logic [PC_W-1:0]  pend_addr_q, pend_addr_d;
  asm_state_e       state_q, state_d;
  logic             valid_q, valid_d;
  logic [7:0]       icode_q, icode_d, b2_q, b2_d, b3_q, b3_d;
  logic [1:0]       len_q, len_d;
  logic [PC_W-1:0]  pc_q, pc_d;

  logic             fifo_empty, issue, push, pop, take_op;
  logic [7:0]       head_dat;
  logic [PC_W-1:0]  head_tag;

  assign fifo_empty = (count_q == '0);
  assign head_dat   = fifo_dat_q[rd_ptr_q];
  assign head_tag   = fifo_tag_q[rd_ptr_q];
  assign take_op    = (state_q == ST_OP) || ((state_q == ST_OUT) && INS_READY_I);

  // Next-state logic: assembler pops, byte returns, ROM issue, then redirect overrides all.
  always_comb begin
    stack_d     = stack_q;
    sp_d        = sp_q;
    sp_inc      = sp_q + 3'd1;
    fifo_dat_d  = fifo_dat_q;
    fifo_tag_d  = fifo_tag_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    pend_d      = 1'b0;
    pend_addr_d = pend_addr_q;
    state_d     = state_q;
    valid_d     = valid_q;
    icode_d     = icode_q;
    b2_d        = b2_q;
    b3_d        = b3_q;
    len_d       = len_q;
    pc_d        = pc_q;
    pop         = 1'b0;
    push        = pend_q;
    issue       = !BR_VALID_I &&
                  (({1'b0, count_q} + (CNT_W + 1)'(pend_q)) < DEPTH_C);

    case (state_q)
      ST_OP, ST_OUT: begin
        if ((state_q == ST_OUT) && INS_READY_I) begin
          valid_d = 1'b0;
          state_d = ST_OP;
        end
        if (take_op && !fifo_empty) begin
          pop     = 1'b1;
          icode_d = head_dat;
          pc_d    = head_tag;
          b2_d    = 8'h00;
          b3_d    = 8'h00;
          len_d   = op_len(head_dat);
          if (op_len(head_dat) == 2'd1) begin
            state_d = ST_OUT;
            valid_d = 1'b1;
          end else begin
            state_d = ST_B2;
          end
        end
      end
      ST_B2: begin
        if (!fifo_empty) begin
          pop  = 1'b1;
          b2_d = head_dat;
          if (len_q == 2'd2) begin
            state_d = ST_OUT;
            valid_d = 1'b1;
          end else begin
            state_d = ST_B3;
          end
        end
      end
      ST_B3: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          b3_d    = head_dat;
          state_d = ST_OUT;
          valid_d = 1'b1;
        end
      end
      default: state_d = ST_OP;
    endcase

    if (push) begin
      fifo_dat_d[wr_ptr_q] = I_DAT_I;
      fifo_tag_d[wr_ptr_q] = pend_addr_q;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (issue) begin
      pend_d           = 1'b1;
      pend_addr_d      = stack_q[sp_q];
      stack_d[sp_q]    = stack_q[sp_q] + PC_W'(1);
    end

    if (BR_VALID_I) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pend_d   = 1'b0;
      state_d  = ST_OP;
      valid_d  = 1'b0;
      case (BR_TYPE_I)
        2'b00: stack_d[sp_q] = BR_ADDR_I;
        2'b01: begin
          stack_d[sp_q]   = BR_LINK_I;
          stack_d[sp_inc] = BR_ADDR_I;
          sp_d            = sp_inc;
        end
        2'b10: sp_d = sp_q - 3'd1;
        default: sp_d = sp_q;
      endcase
    end
  end

  // Control and instruction registers; reset clears the stack and drops all fetch state.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      stack_q     <= '{default: '0};
      sp_q        <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      state_q     <= ST_OP;
      valid_q     <= 1'b0;
      icode_q     <= '0;
      b2_q        <= '0;
      b3_q        <= '0;
      len_q       <= '0;
      pc_q        <= '0;
    end else begin
      stack_q     <= stack_d;
      sp_q        <= sp_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      state_q     <= state_d;
      valid_q     <= valid_d;
      icode_q     <= icode_d;
      b2_q        <= b2_d;
      b3_q        <= b3_d;
      len_q       <= len_d;
      pc_q        <= pc_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge CLK_I) begin
    fifo_dat_q <= fifo_dat_d;
    fifo_tag_q <= fifo_tag_d;
  end

  assign I_ADDR_O    = stack_q[sp_q];
  assign SP_O        = sp_q;
  assign INS_VALID_O = valid_q;
  assign INS_ICODE_O = icode_q;
  assign INS_B2_O    = b2_q;
  assign INS_B3_O    = b3_q;
  assign INS_LEN_O   = len_q;
  assign INS_PC_O    = pc_q;
  assign INS_NEXT_O  = pc_q + PC_W'(len_q);

endmodule

// File: tb/tb_mcs8_fetch_unit.sv
// Directed bench for mcs8_fetch_unit: ROM model, instruction scoreboard and
// checks of stack, redirect, stall and reset behaviour.
module tb_mcs8_fetch_unit;

  localparam int PC_W       = 14;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [7:0]      icode;
    logic [7:0]      b2;
    logic [7:0]      b3;
    logic [1:0]      len;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] next;
  } instr_t;

  logic            CLK_I = 1'b0;
  logic            RST_I;
  logic [PC_W-1:0] I_ADDR_O;
  logic [7:0]      I_DAT_I;
  logic            INS_VALID_O;
  logic            INS_READY_I;
  logic [7:0]      INS_ICODE_O, INS_B2_O, INS_B3_O;
  logic [1:0]      INS_LEN_O;
  logic [PC_W-1:0] INS_PC_O, INS_NEXT_O;
  logic            BR_VALID_I;
  logic [1:0]      BR_TYPE_I;
  logic [PC_W-1:0] BR_ADDR_I, BR_LINK_I;
  logic [2:0]      SP_O;

  logic [7:0] rom [0:(1<<PC_W)-1];
  instr_t     sb[$];
  int         accCycle[$];
  instr_t     expInstr;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  mcs8_fetch_unit #(.FIFO_DEPTH(FIFO_DEPTH), .PC_W(PC_W)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .I_ADDR_O(I_ADDR_O), .I_DAT_I(I_DAT_I),
    .INS_VALID_O(INS_VALID_O), .INS_READY_I(INS_READY_I),
    .INS_ICODE_O(INS_ICODE_O), .INS_B2_O(INS_B2_O), .INS_B3_O(INS_B3_O),
    .INS_LEN_O(INS_LEN_O), .INS_PC_O(INS_PC_O), .INS_NEXT_O(INS_NEXT_O),
    .BR_VALID_I(BR_VALID_I), .BR_TYPE_I(BR_TYPE_I), .BR_ADDR_I(BR_ADDR_I),
    .BR_LINK_I(BR_LINK_I), .SP_O(SP_O)
  );

  always #5 CLK_I = ~CLK_I;

  always @(posedge CLK_I) cyc <= cyc + 1;

  // Synchronous ROM: data for the presented address appears one cycle later.
  always @(posedge CLK_I) I_DAT_I <= rom[I_ADDR_O];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [1:0] modelLen(input logic [7:0] op);
    if (op[7] == 1'b0 && op[6] == 1'b0 && op[2] == 1'b1 && op[0] == 1'b0) return 2'd2;
    if (op[7] == 1'b0 && op[6] == 1'b1 && op[0] == 1'b0) return 2'd3;
    return 2'd1;
  endfunction

  // Walk the ROM image from start and queue the next n instructions decode should see.
  task automatic pushExpect(input logic [PC_W-1:0] start, input int n);
    logic [PC_W-1:0] pc;
    instr_t e;
    pc = start;
    for (int k = 0; k < n; k++) begin
      e.icode = rom[pc];
      e.len   = modelLen(e.icode);
      e.b2    = (e.len >= 2'd2) ? rom[pc + 14'd1] : 8'h00;
      e.b3    = (e.len == 2'd3) ? rom[pc + 14'd2] : 8'h00;
      e.pc    = pc;
      e.next  = pc + 14'(e.len);
      sb.push_back(e);
      pc = e.next;
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] t,
                               input logic [PC_W-1:0] a, input logic [PC_W-1:0] l,
                               input logic rdy);
    BR_VALID_I  = v;
    BR_TYPE_I   = t;
    BR_ADDR_I   = a;
    BR_LINK_I   = l;
    INS_READY_I = rdy;
    tick();
  endtask

  task automatic drain(input string tag);
    INS_READY_I = 1'b1;
    for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
    INS_READY_I = 1'b0;
    checkOutput(tag, 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: every accepted instruction must match the oldest queued expectation.
  always @(negedge CLK_I) begin
    if (!RST_I && INS_VALID_O && INS_READY_I && !BR_VALID_I) begin
      accCycle.push_back(cyc);
      checkOutput("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        expInstr = sb.pop_front();
        checkOutput("ins_icode", 32'(INS_ICODE_O), 32'(expInstr.icode));
        checkOutput("ins_b2",    32'(INS_B2_O),    32'(expInstr.b2));
        checkOutput("ins_b3",    32'(INS_B3_O),    32'(expInstr.b3));
        checkOutput("ins_len",   32'(INS_LEN_O),   32'(expInstr.len));
        checkOutput("ins_pc",    32'(INS_PC_O),    32'(expInstr.pc));
        checkOutput("ins_next",  32'(INS_NEXT_O),  32'(expInstr.next));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [PC_W-1:0] addrHold;
    logic [2:0]      spExp;
    int              rc, n0, diff;

    for (int i = 0; i < (1 << PC_W); i++)
      rom[i] = (i == 0) ? 8'h00 : (8'hC0 | 8'(i & 63));

    RST_I = 1'b1;
    INS_READY_I = 1'b0;
    BR_VALID_I = 1'b0;
    BR_TYPE_I = 2'b00;
    BR_ADDR_I = '0;
    BR_LINK_I = '0;
    tick();
    tick();

    // Reset state
    checkOutput("rst_addr",  32'(I_ADDR_O),    32'd0);
    checkOutput("rst_sp",    32'(SP_O),        32'd0);
    checkOutput("rst_valid", 32'(INS_VALID_O), 32'd0);
    checkOutput("rst_icode", 32'(INS_ICODE_O), 32'd0);
    checkOutput("rst_b2",    32'(INS_B2_O),    32'd0);
    checkOutput("rst_b3",    32'(INS_B3_O),    32'd0);
    checkOutput("rst_len",   32'(INS_LEN_O),   32'd0);
    checkOutput("rst_pc",    32'(INS_PC_O),    32'd0);
    checkOutput("rst_next",  32'(INS_NEXT_O),  32'd0);

    // Single-byte stream with continuous ready
    RST_I = 1'b0;
    pushExpect(14'h0000, 40);
    INS_READY_I = 1'b1;
    for (int i = 0; i < 100 && accCycle.size() < 8; i++) tick();
    checkOutput("fill_count", 32'(accCycle.size() >= 8), 32'd1);
    diff = (accCycle.size() >= 8) ? (accCycle[7] - accCycle[0]) : -1;
    checkOutput("throughput", 32'(diff), 32'd7);

    // Decode stall: output held, fetch stops once the FIFO is full
    INS_READY_I = 1'b0;
    addrHold = '0;
    for (int s = 1; s <= 10; s++) begin
      tick();
      checkOutput("stall_valid", 32'(INS_VALID_O), 32'd1);
      checkOutput("stall_pc",    32'(INS_PC_O),    32'(sb[0].pc));
      checkOutput("stall_icode", 32'(INS_ICODE_O), 32'(sb[0].icode));
      if (s == 5) addrHold = I_ADDR_O;
      if (s == 10) begin
        checkOutput("stall_addr_hold", 32'(I_ADDR_O), 32'(addrHold));
        checkOutput("stall_addr_full", 32'(I_ADDR_O),
                    32'(sb[0].pc + 14'(FIFO_DEPTH + 1)));
      end
    end
    drain("drain_stream");

    // CALL with a same-cycle handshake that must not count
    rc = cyc;
    n0 = accCycle.size();
    applyStimulus(1'b1, 2'b01, 14'h0100, 14'h0005, 1'b1);
    BR_VALID_I = 1'b0;
    INS_READY_I = 1'b0;
    checkOutput("call_sp",    32'(SP_O),        32'd1);
    checkOutput("call_addr",  32'(I_ADDR_O),    32'h0100);
    checkOutput("call_valid", 32'(INS_VALID_O), 32'd0);
    pushExpect(14'h0100, 6);
    drain("drain_call");
    diff = (accCycle.size() > n0) ? (accCycle[n0] - rc) : -1;
    checkOutput("call_latency", 32'(diff >= 3), 32'd1);

    // RET back to the link address
    applyStimulus(1'b1, 2'b10, 14'h0000, 14'h0000, 1'b0);
    BR_VALID_I = 1'b0;
    checkOutput("ret_sp",    32'(SP_O),        32'd0);
    checkOutput("ret_addr",  32'(I_ADDR_O),    32'h0005);
    checkOutput("ret_valid", 32'(INS_VALID_O), 32'd0);
    pushExpect(14'h0005, 6);
    drain("drain_ret");

    // Nine back-to-back CALLs wrap the stack, then two RETs
    spExp = SP_O;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, 2'b01, 14'(14'h0200 + k), 14'(14'h0300 + k), 1'b0);
      spExp = spExp + 3'd1;
      checkOutput("ncall_sp", 32'(SP_O), 32'(spExp));
    end
    applyStimulus(1'b1, 2'b10, 14'h0000, 14'h0000, 1'b0);
    checkOutput("wrap_ret_sp",   32'(SP_O),     32'd0);
    checkOutput("wrap_ret_addr", 32'(I_ADDR_O), 32'h0308);
    applyStimulus(1'b1, 2'b10, 14'h0000, 14'h0000, 1'b0);
    BR_VALID_I = 1'b0;
    checkOutput("under_ret_sp",   32'(SP_O),     32'd7);
    checkOutput("under_ret_addr", 32'(I_ADDR_O), 32'h0307);
    pushExpect(14'h0307, 4);
    drain("drain_wrap");

    // Reserved type: flush only, stack untouched
    addrHold = I_ADDR_O;
    applyStimulus(1'b1, 2'b11, 14'h0123, 14'h0077, 1'b0);
    BR_VALID_I = 1'b0;
    checkOutput("rsv_sp",    32'(SP_O),        32'd7);
    checkOutput("rsv_addr",  32'(I_ADDR_O),    32'(addrHold));
    checkOutput("rsv_valid", 32'(INS_VALID_O), 32'd0);
    pushExpect(addrHold, 3);
    drain("drain_rsv");

    // Reset in the middle of assembling a triple
    rom[0] = 8'h06; rom[1] = 8'h5A; rom[2] = 8'h44; rom[3] = 8'h34; rom[4] = 8'h12;
    rom[14'h0400] = 8'h44; rom[14'h0401] = 8'h34; rom[14'h0402] = 8'h12;
    rom[14'h3FFF] = 8'h06;
    applyStimulus(1'b1, 2'b00, 14'h0400, 14'h0000, 1'b0);
    BR_VALID_I = 1'b0;
    checkOutput("jmp_addr", 32'(I_ADDR_O), 32'h0400);
    checkOutput("jmp_sp",   32'(SP_O),     32'd7);
    tick();
    tick();
    tick();
    #3;
    RST_I = 1'b1;
    #1;
    checkOutput("async_valid", 32'(INS_VALID_O), 32'd0);
    checkOutput("async_icode", 32'(INS_ICODE_O), 32'd0);
    checkOutput("async_len",   32'(INS_LEN_O),   32'd0);
    checkOutput("async_pc",    32'(INS_PC_O),    32'd0);
    checkOutput("async_addr",  32'(I_ADDR_O),    32'd0);
    checkOutput("async_sp",    32'(SP_O),        32'd0);
    tick();
    RST_I = 1'b0;
    checkOutput("rel_addr0", 32'(I_ADDR_O), 32'd0);
    pushExpect(14'h0000, 3);
    tick();
    checkOutput("rel_addr1", 32'(I_ADDR_O), 32'd1);
    drain("drain_reset");

    // Address wrap at the top of the ROM
    applyStimulus(1'b1, 2'b00, 14'h3FFE, 14'h0000, 1'b0);
    BR_VALID_I = 1'b0;
    checkOutput("top_addr", 32'(I_ADDR_O), 32'h3FFE);
    pushExpect(14'h3FFE, 4);
    drain("drain_top");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
